// File: rtl/frame_sync_gate.sv
// frame_sync_gate
//   Input conditioning stage ahead of the mean filter. Locks onto start of
//   frame (tuser), checks every line length (tlast) against FRAME_WIDTH and
//   repairs malformed frames. Downstream therefore always sees exactly
//   FRAME_WIDTH x FRAME_HEIGHT beats per frame, with regenerated tuser/tlast.
//   A registered 2-entry skid buffer isolates the upstream ready from the
//   downstream ready.
// Ports
//   clk, rst                 single clock, asynchronous active-high reset
//   s_axis_*                 upstream AXI-Stream (tready is registered)
//   m_axis_*                 downstream AXI-Stream (all outputs registered)
//   err_early_eol            1-cycle pulse: tlast before the last column
//   err_late_eol             1-cycle pulse: no tlast on the last column
//   err_early_sof            1-cycle pulse: tuser on a mid-frame beat
//   frame_cnt                complete frames emitted, wraps at 2^16
module frame_sync_gate #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  err_early_eol,
  output logic                  err_late_eol,
  output logic                  err_early_sof,
  output logic [15:0]           frame_cnt
);

  localparam int HW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int VW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(FRAME_WIDTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_HEIGHT - 1);
  // Buffer entry layout: {eof, tuser, tlast, data}
  localparam int EW = DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    ACTIVE    = 2'd1,
    PAD       = 2'd2,
    DROP_LINE = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [HW-1:0]         hcnt_r;
  logic [VW-1:0]         vcnt_r;
  logic [EW-1:0]         ent0_r, ent1_r;
  logic                  v0_r, v1_r;
  logic                  tready_r;
  logic                  pend_v_r, pend_last_r;
  logic [DATA_WIDTH-1:0] pend_data_r;
  logic                  err_early_eol_r, err_late_eol_r, err_early_sof_r;
  logic [15:0]           frame_cnt_r;

  logic                  s_fire_s, pop_s, room_s;
  logic                  at_origin_s, last_col_s, last_px_s;
  logic [1:0]            cnt_s, cnt_n_s;
  logic                  push_s, fwd_s, fwd_last_s, pend_set_s, pend_clr_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic [EW-1:0]         push_ent_s;
  logic                  err_early_eol_s, err_late_eol_s, err_early_sof_s;

  // Where the FSM goes after a real (non-padding) beat has been forwarded.
  function automatic state_t after_fwd(input logic in_last, input logic lc, input logic lp);
    state_t nxt;
    if (in_last && !lc) begin
      nxt = PAD;
    end else if (!in_last && lc) begin
      nxt = lp ? WAIT_SOF : DROP_LINE;
    end else if (lp) begin
      nxt = WAIT_SOF;
    end else begin
      nxt = ACTIVE;
    end
    return nxt;
  endfunction

  assign s_fire_s    = s_axis_tvalid & tready_r;
  assign pop_s       = v0_r & m_axis_tready;
  assign cnt_s       = {1'b0, v0_r} + {1'b0, v1_r};
  assign room_s      = (cnt_s < 2'd2);
  assign at_origin_s = (hcnt_r == {HW{1'b0}}) && (vcnt_r == {VW{1'b0}});
  assign last_col_s  = (hcnt_r == H_LAST);
  assign last_px_s   = last_col_s && (vcnt_r == V_LAST);
  // tuser/tlast are regenerated purely from the write-side position.
  assign push_ent_s  = {last_px_s, at_origin_s, last_col_s, push_data_s};
  assign cnt_n_s     = cnt_s + {1'b0, push_s} - {1'b0, pop_s};

  // Next-state logic: decides what (if anything) is written into the buffer.
  always_comb begin
    state_s         = state_r;
    push_s          = 1'b0;
    fwd_s           = 1'b0;
    fwd_last_s      = 1'b0;
    push_data_s     = {DATA_WIDTH{1'b0}};
    pend_set_s      = 1'b0;
    pend_clr_s      = 1'b0;
    err_early_sof_s = 1'b0;
    case (state_r)
      WAIT_SOF: begin
        // tuser wins over tlast; tlast is then judged like any other beat.
        if (s_fire_s && s_axis_tuser) begin
          push_s      = 1'b1;
          fwd_s       = 1'b1;
          fwd_last_s  = s_axis_tlast;
          push_data_s = s_axis_tdata;
          state_s     = after_fwd(s_axis_tlast, last_col_s, last_px_s);
        end else begin
          state_s = WAIT_SOF;
        end
      end
      ACTIVE: begin
        if (s_fire_s) begin
          if (s_axis_tuser && !at_origin_s) begin
            err_early_sof_s = 1'b1;
            pend_set_s      = 1'b1;
            state_s         = PAD;
          end else begin
            push_s      = 1'b1;
            fwd_s       = 1'b1;
            fwd_last_s  = s_axis_tlast;
            push_data_s = s_axis_tdata;
            state_s     = after_fwd(s_axis_tlast, last_col_s, last_px_s);
          end
        end else begin
          state_s = ACTIVE;
        end
      end
      PAD: begin
        // Counters wrap to the origin once the padded frame is complete.
        if (!at_origin_s) begin
          push_s = room_s;
        end else if (pend_v_r) begin
          if (room_s) begin
            push_s      = 1'b1;
            fwd_s       = 1'b1;
            fwd_last_s  = pend_last_r;
            push_data_s = pend_data_r;
            pend_clr_s  = 1'b1;
            state_s     = after_fwd(pend_last_r, last_col_s, last_px_s);
          end else begin
            state_s = PAD;
          end
        end else begin
          state_s = WAIT_SOF;
        end
      end
      DROP_LINE: begin
        if (s_fire_s) begin
          if (s_axis_tuser) begin
            err_early_sof_s = 1'b1;
            pend_set_s      = 1'b1;
            state_s         = PAD;
          end else if (s_axis_tlast) begin
            state_s = ACTIVE;
          end else begin
            state_s = DROP_LINE;
          end
        end else begin
          state_s = DROP_LINE;
        end
      end
      default: begin
        state_s = WAIT_SOF;
      end
    endcase
  end

  // Line-length checks on forwarded beats; one pulse per cycle, SOF highest.
  always_comb begin
    err_early_eol_s = fwd_s & fwd_last_s & ~last_col_s & ~err_early_sof_s;
    err_late_eol_s  = fwd_s & ~fwd_last_s & last_col_s & ~err_early_sof_s & ~err_early_eol_s;
  end

  // FSM, position counters, pending SOF, error pulses and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= WAIT_SOF;
      hcnt_r          <= {HW{1'b0}};
      vcnt_r          <= {VW{1'b0}};
      pend_v_r        <= 1'b0;
      pend_last_r     <= 1'b0;
      pend_data_r     <= {DATA_WIDTH{1'b0}};
      err_early_eol_r <= 1'b0;
      err_late_eol_r  <= 1'b0;
      err_early_sof_r <= 1'b0;
      frame_cnt_r     <= 16'd0;
    end else begin
      state_r         <= state_s;
      err_early_eol_r <= err_early_eol_s;
      err_late_eol_r  <= err_late_eol_s;
      err_early_sof_r <= err_early_sof_s;
      if (push_s) begin
        if (last_col_s) begin
          hcnt_r <= {HW{1'b0}};
          vcnt_r <= (vcnt_r == V_LAST) ? {VW{1'b0}} : vcnt_r + {{(VW-1){1'b0}}, 1'b1};
        end else begin
          hcnt_r <= hcnt_r + {{(HW-1){1'b0}}, 1'b1};
        end
      end
      if (pend_set_s) begin
        pend_v_r    <= 1'b1;
        pend_last_r <= s_axis_tlast;
        pend_data_r <= s_axis_tdata;
      end else if (pend_clr_s) begin
        pend_v_r <= 1'b0;
      end
      if (pop_s && ent0_r[EW-1]) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  // Skid buffer: ent0 drives the outputs, ent1 absorbs one beat of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_r   <= {EW{1'b0}};
      ent1_r   <= {EW{1'b0}};
      v0_r     <= 1'b0;
      v1_r     <= 1'b0;
      tready_r <= 1'b0;
    end else begin
      // Ready is computed from next occupancy, so it never sees m_axis_tready combinationally.
      tready_r <= (cnt_n_s < 2'd2) && (state_s != PAD);
      if (pop_s) begin
        if (v1_r) begin
          ent0_r <= ent1_r;
          if (push_s) begin
            ent1_r <= push_ent_s;
          end else begin
            v1_r <= 1'b0;
          end
        end else if (push_s) begin
          ent0_r <= push_ent_s;
        end else begin
          v0_r <= 1'b0;
        end
      end else if (push_s) begin
        if (!v0_r) begin
          ent0_r <= push_ent_s;
          v0_r   <= 1'b1;
        end else begin
          ent1_r <= push_ent_s;
          v1_r   <= 1'b1;
        end
      end
    end
  end

  assign s_axis_tready = tready_r;
  assign m_axis_tvalid = v0_r;
  assign m_axis_tdata  = ent0_r[DATA_WIDTH-1:0];
  assign m_axis_tlast  = ent0_r[DATA_WIDTH];
  assign m_axis_tuser  = ent0_r[DATA_WIDTH+1];
  assign err_early_eol = err_early_eol_r;
  assign err_late_eol  = err_late_eol_r;
  assign err_early_sof = err_early_sof_r;
  assign frame_cnt     = frame_cnt_r;

endmodule

// File: tb/tb_frame_sync_gate.sv
// tb_frame_sync_gate
//   Directed bench for frame_sync_gate with a 4x3 frame and 8-bit pixels.
module tb_frame_sync_gate;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last, s_user, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, m_user, m_ready;
  logic          e_eeol, e_leol, e_esof;
  logic [15:0]   frame_cnt;

  frame_sync_gate #(.DATA_WIDTH(DW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
    .s_axis_tuser(s_user), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
    .m_axis_tuser(m_user), .m_axis_tready(m_ready),
    .err_early_eol(e_eeol), .err_late_eol(e_leol), .err_early_sof(e_esof),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready source: fixed level or 50% random.
  logic fixed_ready, rand_en, ind_en;
  logic rdy_pre_r;
  always @(negedge clk) begin
    rdy_pre_r <= s_ready;
    m_ready   <= rand_en ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  // Output monitor: collects accepted beats, checks stall stability and ready independence.
  logic [9:0] out_q[$];
  logic       hold_r;
  logic [9:0] prev_r;
  always @(posedge clk) begin
    if (rst) begin
      hold_r <= 1'b0;
    end else begin
      if (hold_r) chk("stall_stable", {m_valid, m_user, m_last, m_data}, {1'b1, prev_r});
      if (ind_en) chk("tready_indep", s_ready, rdy_pre_r);
      if (m_valid && m_ready) out_q.push_back({m_user, m_last, m_data});
      hold_r <= m_valid && !m_ready;
      prev_r <= {m_user, m_last, m_data};
    end
  end

  // Error pulse counters.
  int n_eeol = 0, n_leol = 0, n_esof = 0, n_multi = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (e_eeol) n_eeol <= n_eeol + 1;
      if (e_leol) n_leol <= n_leol + 1;
      if (e_esof) n_esof <= n_esof + 1;
      if ((32'(e_eeol) + 32'(e_leol) + 32'(e_esof)) > 32'd1) n_multi <= n_multi + 1;
    end
  end

  logic [9:0] exp_q[$];

  task automatic ex(input int d, input bit u, input bit l);
    exp_q.push_back({u, l, 8'(d)});
  endtask

  task automatic send(input int d, input bit u, input bit l);
    int t;
    t = 0;
    @(negedge clk);
    s_data = 8'(d); s_user = u; s_last = l; s_valid = 1'b1;
    while (s_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", s_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < W * H; i++) send(base + i, i == 0, (i % W) == W - 1);
  endtask

  task automatic exp_frame(input int base);
    for (int i = 0; i < W * H; i++) ex(base + i, i == 0, (i % W) == W - 1);
  endtask

  task automatic wait_frame(input int target);
    int t;
    t = 0;
    while (frame_cnt !== 16'(target) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("frame_cnt", frame_cnt, target);
  endtask

  // Compares the oldest output beats against exp_q, optionally requiring an exact count.
  task automatic check_beats(input string tag, input bit exact);
    logic [9:0] got;
    if (exact) chk({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (out_q.size() > 0) got = out_q.pop_front();
      else got = 10'h3ff;
      chk(tag, got, exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic chk_errs(input int ee, input int le, input int es);
    chk("err_early_eol_cnt", n_eeol, ee);
    chk("err_late_eol_cnt", n_leol, le);
    chk("err_early_sof_cnt", n_esof, es);
    chk("err_multi_cnt", n_multi, 0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; s_user = 1'b0; s_last = 1'b0;
    fixed_ready = 1'b1; rand_en = 1'b0; ind_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_errs", {e_eeol, e_leol, e_esof}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1'b1);
    ind_en = 1'b1;

    // 1: clean frame
    send_frame(1); idle();
    exp_frame(1);
    wait_frame(1);
    check_beats("t1_beat", 1'b1);
    chk_errs(0, 0, 0);

    // 2: junk before SOF is discarded
    send(7, 1'b0, 1'b0); send(8, 1'b0, 1'b0); send(9, 1'b0, 1'b0);
    send_frame(21); idle();
    exp_frame(21);
    wait_frame(2);
    check_beats("t2_beat", 1'b1);
    chk_errs(0, 0, 0);

    // 3: line 1 ends at column 1 -> padded
    for (int i = 0; i < 4; i++) send(41 + i, i == 0, i == 3);
    send(45, 1'b0, 1'b0);
    send(46, 1'b0, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t3_pad_s_ready", s_ready, 1'b0);
    ex(41, 1, 0); ex(42, 0, 0); ex(43, 0, 0); ex(44, 0, 1); ex(45, 0, 0); ex(46, 0, 0);
    ex(0, 0, 0); ex(0, 0, 1); ex(0, 0, 0); ex(0, 0, 0); ex(0, 0, 0); ex(0, 0, 1);
    wait_frame(3);
    check_beats("t3_beat", 1'b1);
    chk_errs(1, 0, 0);

    // 4: line 0 is 6 beats long
    for (int i = 0; i < 6; i++) send(51 + i, i == 0, i == 5);
    for (int i = 0; i < 8; i++) send(57 + i, 1'b0, (i % 4) == 3);
    idle();
    ex(51, 1, 0); ex(52, 0, 0); ex(53, 0, 0); ex(54, 0, 1);
    for (int i = 0; i < 8; i++) ex(57 + i, 0, (i % 4) == 3);
    wait_frame(4);
    check_beats("t4_beat", 1'b1);
    chk_errs(1, 1, 0);

    // 5: SOF at column 2 of line 1 -> pad, then it starts the next frame
    for (int i = 0; i < 6; i++) send(71 + i, i == 0, i == 3);
    send(8'hAA, 1'b1, 1'b0);
    for (int p = 1; p < W * H; p++) send(80 + p, 1'b0, (p % W) == W - 1);
    idle();
    for (int i = 0; i < 6; i++) ex(71 + i, i == 0, i == 3);
    ex(0, 0, 0); ex(0, 0, 1); ex(0, 0, 0); ex(0, 0, 0); ex(0, 0, 0); ex(0, 0, 1);
    wait_frame(5);
    check_beats("t5_pad_beat", 1'b0);
    ex(8'hAA, 1, 0);
    for (int p = 1; p < W * H; p++) ex(80 + p, 0, (p % W) == W - 1);
    wait_frame(6);
    check_beats("t5_next_beat", 1'b1);
    chk_errs(1, 1, 1);

    // 6: random downstream backpressure
    rand_en = 1'b1;
    send_frame(101); idle();
    exp_frame(101);
    wait_frame(7);
    check_beats("t6_beat", 1'b1);
    chk_errs(1, 1, 1);

    // Reset mid-frame with beats held in the buffer
    rand_en = 1'b0; fixed_ready = 1'b0;
    idle(); idle();
    send(121, 1'b1, 1'b0); send(122, 1'b0, 1'b0);
    idle();
    chk("mid_m_valid_before", m_valid, 1'b1);
    ind_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_frame_cnt", frame_cnt, 16'd0);
    chk("mid_rst_s_ready", s_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    fixed_ready = 1'b1;
    out_q.delete();
    @(negedge clk);
    chk("mid_post_rst_s_ready", s_ready, 1'b1);
    ind_en = 1'b1;
    send_frame(131); idle();
    exp_frame(131);
    wait_frame(1);
    check_beats("t7_beat", 1'b1);
    chk_errs(1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
